// File: rtl/dual_cache_arbiter.sv
// Arbitrates a D-cache (requester 0) and an I-cache (requester 1) onto one memory
// beat port with single-word or 4-word-burst transactions. Define ARB_ROUND_ROBIN_EN
// for round-robin arbitration; otherwise requester 0 has fixed priority.
module dual_cache_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_i,
  input  logic [1:0]  wr_i,
  input  logic [1:0]  burst_i,
  input  logic [15:0] addr0_i,
  input  logic [15:0] addr1_i,
  input  logic [15:0] wdata0_i,
  input  logic [15:0] wdata1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  iss_offset_o,
  output logic        rd_valid_o,
  output logic [1:0]  rd_offset_o,
  output logic [15:0] rd_data_o,
  output logic [1:0]  done_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_stall_i
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WDONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [OW-1:0]   cnt_q, cnt_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]      done_q, done_d;

  // Read-return pipe: valid, last-beat flag and word offset per stage
  logic [MEM_LAT-1:0]         pv_q, pv_d;
  logic [MEM_LAT-1:0]         pl_q, pl_d;
  logic [MEM_LAT-1:0][OW-1:0] po_q, po_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;
`endif

  logic          win;
  logic [AW-1:0] win_addr;
  logic          own_idx;
  logic          own_burst;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          accept;
  logic          last_beat;
  logic          rd_last;

  // Winner selection among the current requests
  always_comb begin
    win = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (req_i == 2'b11) begin
      win = rr_q;
    end else begin
      win = req_i[1];
    end
`else
    win = ~req_i[0];
`endif
  end

  assign win_addr  = win ? addr1_i : addr0_i;
  assign own_idx   = gnt_q[1];
  assign own_burst = burst_i[own_idx];
  assign own_addr  = own_idx ? addr1_i : addr0_i;
  assign own_wdata = own_idx ? wdata1_i : wdata0_i;
  assign accept    = (mem_rd_q | mem_wr_q) & ~mem_stall_i;
  assign last_beat = own_burst ? (cnt_q == OW'(3)) : 1'b1;
  assign rd_last   = pv_q[MEM_LAT-1] & pl_q[MEM_LAT-1];

  // Shift pipe tracking accepted read beats until their data returns
  always_comb begin
    pv_d    = pv_q;
    pl_d    = pl_q;
    po_d    = po_q;
    pv_d[0] = accept & mem_rd_q;
    pl_d[0] = accept & mem_rd_q & last_beat;
    po_d[0] = cnt_q;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
      po_d[i] = po_q[i-1];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    done_d     = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          state_d    = ISSUE;
          gnt_d      = win ? 2'b10 : 2'b01;
          cnt_d      = '0;
          mem_rd_d   = ~wr_i[win];
          mem_wr_d   = wr_i[win];
          mem_addr_d = burst_i[win] ? {win_addr[AW-1:3], 3'b000} : win_addr;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d       = ~win;
`endif
        end
      end
      ISSUE: begin
        if (accept) begin
          if (last_beat) begin
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
            if (mem_wr_q) begin
              state_d = WDONE;
              done_d  = gnt_q;
            end else begin
              state_d = WAIT;
            end
          end else begin
            cnt_d      = cnt_q + OW'(1);
            mem_addr_d = {own_addr[AW-1:3], cnt_d, 1'b0};
          end
        end
      end
      WAIT: begin
        if (rd_last) begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      end
      WDONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    // Read completion lines up with the last returned word
    if (pv_d[MEM_LAT-1] && pl_d[MEM_LAT-1]) begin
      done_d = gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      cnt_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      done_q     <= 2'b00;
      pv_q       <= '0;
      pl_q       <= '0;
      po_q       <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      pv_q       <= pv_d;
      pl_q       <= pl_d;
      po_q       <= po_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign gnt_o        = gnt_q;
  assign iss_offset_o = cnt_q;
  assign rd_valid_o   = pv_q[MEM_LAT-1];
  assign rd_offset_o  = po_q[MEM_LAT-1];
  assign rd_data_o    = pv_q[MEM_LAT-1] ? mem_rdata_i : '0;
  assign done_o       = done_q;
  assign mem_rd_o     = mem_rd_q;
  assign mem_wr_o     = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  // Requester presents the word for iss_offset, so write data follows the owner live
  assign mem_wdata_o  = mem_wr_q ? own_wdata : '0;

endmodule
